pc_target_table: RTL
====================

// Module: pc_target_table
// PURPOSE
//  Programmable branch-target table; successor to the fixed branch-target LUT. Fetch stage presents a
//  6-bit label index plus current PC. One cycle later the block returns the next-PC target.
//  Each entry holds an absolute address or a signed PC-relative offset, plus a valid bit.
//  Entries are loaded at run time through a write port; an invalid entry falls through to PC+1.
// PARAMETERS
//  D        12  PC / target width (bits); all target arithmetic is modulo 2**D
//  A         6  index width; table depth = 2**A entries
//  FALL_INC  1  increment applied to PC on a miss (invalid entry)
// PORTS
//  Clk        in   1  clock; all state changes on rising edge
//  Reset      in   1  synchronous, active-low reset
//  Ready      out  1  table initialised and accepting lookups/writes
//  Req        in   1  lookup request (qualified by Ready)
//  Addr       in   A  lookup index
//  PC         in   D  PC of the branch instruction
//  Wr_en      in   1  table write (qualified by Ready)
//  Wr_addr    in   A  entry to write
//  Wr_rel     in   1  1 = Wr_data is signed offset, 0 = absolute target
//  Wr_data    in   D  target or two's-complement offset
//  Wr_clr     in   1  with Wr_en: invalidate entry instead of loading it
//  Resp       out  1  lookup result valid (one-cycle pulse per accepted Req)
//  Hit        out  1  entry was valid
//  Target     out  D  next-PC value
// BEHAVIOUR
//  - Reset low at an edge: FSM -> INIT, init counter = 0, Ready=0, Resp=0, Hit=0, Target=0.
//    This applies mid-lookup or mid-INIT; an in-flight Resp is dropped.
//  - INIT: clear valid bit of entry[cnt] each cycle, cnt++.
//    After entry 2**A-1 is cleared, go to RUN (2**A cycles total); Ready=1 from the first RUN cycle.
//  - RUN: Req, Wr_en honoured only when Ready=1; ignored in INIT (no Resp generated).
//  - Write: on edge with Wr_en=1: entry[Wr_addr] <= {valid=~Wr_clr, rel=Wr_rel, data=Wr_data}.
//  - Lookup latency 1: Req sampled at edge N -> Resp=1 with Hit/Target valid after edge N+1 for one cycle.
//    Resp=0 otherwise; Hit/Target hold last value when Resp=0.
//  - Target computation (registered):
//      valid & !rel -> data
//      valid &  rel -> (PC + data) mod 2**D (offset sign-extended; D-bit add, carry discarded)
//      !valid       -> (PC + FALL_INC) mod 2**D, Hit=0
//  - Same-edge write and lookup to same index: lookup sees the NEW entry (write-first bypass).
//    Different indices are independent.
//  - Back-to-back Req every cycle: Resp every cycle, fully pipelined, no stall.
//  - Wrap: PC=4095, offset +1 -> 0; PC=0, offset -1 -> 4095 (D=12).
// STRUCTURE
//  - Package pc_tt_pkg: typedef enum {INIT, RUN} tt_state_t; typedef struct packed {valid, rel, data[D-1:0]}
//    tt_entry_t. Default D/A as localparams.
//  - Storage: flat array of tt_entry_t (register file; no reset on data fields, valid cleared by INIT).
//  - One sub-module: pc_tt_calc -- combinational target calculator (entry, PC -> Target, Hit);
//    registered in the parent.
// TESTING
//  1. Reset low 3 cycles then high -> Ready=0 for exactly 64 cycles, then 1.
//     Req during INIT -> no Resp.
//  2. Write idx1 abs 39, idx2 abs 4; Req idx1 PC=100 -> next cycle Resp=1 Hit=1 Target=39;
//     idx2 -> 4.
//  3. Write idx5 rel -5 (0xFFB); Req PC=4 -> Target=4095; rel +20 at PC=4090 -> Target=14.
//  4. Req unwritten idx9 PC=200 -> Hit=0 Target=201; then Wr_clr idx1, Req idx1 PC=7 -> Hit=0 Target=8.
//  5. Same-edge Wr_en idx3 abs 77 and Req idx3 -> Target=77 Hit=1;
//     Req every cycle over idx0..7 -> Resp each cycle in order.
//  6. Reset asserted the cycle after a Req -> no Resp; Ready=0; all entries invalid after re-INIT.

Source files
------------

// File: rtl/pc_target_table_pkg.sv
// Shared types for the programmable branch-target table: FSM states, entry layout, default widths.
package pc_tt_pkg;
  localparam int D_DEF = 12;
  localparam int A_DEF = 6;

  typedef enum logic {INIT, RUN} tt_state_t;

  // Entry data width follows D_DEF; instances must keep D equal to it.
  typedef struct packed {
    logic              valid;
    logic              rel;
    logic [D_DEF-1:0]  data;
  } tt_entry_t;
endpackage

// File: rtl/pc_target_table_if.sv
// Lookup and write bus between the fetch stage (master) and the target table (slave).
interface pc_target_table_if #(
  parameter int D = 12,
  parameter int A = 6
);
  logic         Ready;
  logic         Req;
  logic [A-1:0] Addr;
  logic [D-1:0] PC;
  logic         Wr_en;
  logic [A-1:0] Wr_addr;
  logic         Wr_rel;
  logic [D-1:0] Wr_data;
  logic         Wr_clr;
  logic         Resp;
  logic         Hit;
  logic [D-1:0] Target;

  modport master (
    input  Ready, Resp, Hit, Target,
    output Req, Addr, PC, Wr_en, Wr_addr, Wr_rel, Wr_data, Wr_clr
  );

  modport slave (
    output Ready, Resp, Hit, Target,
    input  Req, Addr, PC, Wr_en, Wr_addr, Wr_rel, Wr_data, Wr_clr
  );
endinterface

// File: rtl/pc_target_table_calc.sv
// Combinational next-PC calculator for one table entry; the parent registers the result.
module pc_tt_calc
  import pc_tt_pkg::*;
#(
  parameter int D        = D_DEF,
  parameter int FALL_INC = 1
) (
  input  tt_entry_t    entry,
  input  logic [D-1:0] pc,
  output logic         hit,
  output logic [D-1:0] target
);

  // Two's-complement add with the carry dropped gives the modulo-2**D wrap.
  function automatic logic [D-1:0] wrap_add(input logic [D-1:0] base,
                                            input logic signed [D-1:0] off);
    return base + unsigned'(off);
  endfunction

  logic signed [D-1:0] offset;

  always_comb begin
    offset = signed'(entry.data);
    hit    = entry.valid;
    if (!entry.valid) begin
      target = wrap_add(pc, D'(FALL_INC));
    end else if (entry.rel) begin
      target = wrap_add(pc, offset);
    end else begin
      target = entry.data;
    end
  end

endmodule

// File: rtl/pc_target_table.sv
// Programmable branch-target table: INIT sweep clears all valid bits, then RUN serves
// writes and lookups with the next-PC result registered two edges after Req is presented.
module pc_target_table
  import pc_tt_pkg::*;
#(
  parameter int D        = D_DEF,
  parameter int A        = A_DEF,
  parameter int FALL_INC = 1
) (
  input  logic               Clk,
  input  logic               Reset,
  pc_target_table_if.slave   bus
);

  localparam int DEPTH = 2 ** A;

  tt_state_t    state_q, state_d;
  logic [A-1:0] cnt_q, cnt_d;
  logic         req_q, req_d;
  logic [A-1:0] addr_q, addr_d;
  logic [D-1:0] pc_q, pc_d;
  logic         resp_q, resp_d;
  logic         hit_q, hit_d;
  logic [D-1:0] target_q, target_d;
  tt_entry_t    tbl_q [DEPTH];
  tt_entry_t    tbl_d [DEPTH];

  logic         ready;
  logic         wr_fire;
  logic         calc_hit;
  logic [D-1:0] calc_target;

  // A write landing on the capture edge is already in tbl_q when the read happens,
  // which gives write-first behaviour without an explicit bypass path.
  pc_tt_calc #(
    .D        (D),
    .FALL_INC (FALL_INC)
  ) u_calc (
    .entry  (tbl_q[addr_q]),
    .pc     (pc_q),
    .hit    (calc_hit),
    .target (calc_target)
  );

  always_comb begin
    ready    = (state_q == RUN);
    wr_fire  = ready & Reset & bus.Wr_en;
    state_d  = state_q;
    cnt_d    = cnt_q;
    tbl_d    = tbl_q;
    case (state_q)
      INIT: begin
        tbl_d[cnt_q].valid = 1'b0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {A{1'b1}}) state_d = RUN;
      end
      RUN: begin
        if (wr_fire) begin
          tbl_d[bus.Wr_addr] = '{valid: ~bus.Wr_clr, rel: bus.Wr_rel, data: bus.Wr_data};
        end
      end
      default: state_d = INIT;
    endcase

    // Capture stage: request, index and PC.
    req_d  = ready & bus.Req;
    addr_d = bus.Addr;
    pc_d   = bus.PC;

    // Result stage: hit/target only move when a response is produced.
    resp_d   = req_q;
    hit_d    = req_q ? calc_hit    : hit_q;
    target_d = req_q ? calc_target : target_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      resp_q   <= 1'b0;
      hit_q    <= 1'b0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      resp_q   <= resp_d;
      hit_q    <= hit_d;
      target_q <= target_d;
    end
  end

  always_ff @(posedge Clk) begin
    addr_q <= addr_d;
    pc_q   <= pc_d;
    tbl_q  <= tbl_d;
  end

  assign bus.Ready  = ready;
  assign bus.Resp   = resp_q;
  assign bus.Hit    = hit_q;
  assign bus.Target = target_q;

endmodule
